// File: rtl/upower_pkg.sv
// upower_pkg: shared opcode, extended-opcode, DS sub-op and FSM state constants
// for the uPOWER execute/load-store unit.
package upower_pkg;
    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_ORI  = 6'd24;
    localparam logic [5:0] OP_ANDI = 6'd28;
    localparam logic [5:0] OP_X31  = 6'd31;
    localparam logic [5:0] OP_LD   = 6'd58;
    localparam logic [5:0] OP_STD  = 6'd62;
    localparam logic [9:0] XO_ADD  = 10'd266;
    localparam logic [9:0] XO_AND  = 10'd28;
    localparam logic [1:0] DS_PLAIN  = 2'b00;
    localparam logic [1:0] DS_UPDATE = 2'b01;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_MEM  = 2'd2;
    localparam state_t ST_WB   = 2'd3;
endpackage

// File: rtl/upower_gpr_file.sv
// upower_gpr_file: NREG x XLEN register file, three combinational read ports,
// one synchronous write port (indices >= NREG dropped), async active-low clear.
module upower_gpr_file #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_ra_a,
    input  logic [4:0]      i_ra_b,
    input  logic [4:0]      i_ra_d,
    output logic [XLEN-1:0] o_rd_a,
    output logic [XLEN-1:0] o_rd_b,
    output logic [XLEN-1:0] o_rd_d,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);
    localparam int IW = $clog2(NREG);
    logic [XLEN-1:0] r_gpr [NREG];
    assign o_rd_a = r_gpr[i_ra_a[IW-1:0]];
    assign o_rd_b = r_gpr[i_ra_b[IW-1:0]];
    assign o_rd_d = r_gpr[i_ra_d[IW-1:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
        end else if (i_we && int'(i_wa) < NREG) begin
            r_gpr[i_wa[IW-1:0]] <= i_wd;
        end
    end
endmodule

// File: rtl/upower_lsu_exec.sv
// upower_lsu_exec: multi-cycle IDLE/EXEC/MEM/WB execute and load/store unit.
// UPOWER_LDST_UPDATE_EN enables the ldu/stdu (DS=01) base-update forms.
module upower_lsu_exec
    import upower_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int NREG        = 32,
    parameter int MAW         = 16,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic            done,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [MAW-1:0]  mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    state_t          r_state;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_res, r_ea, r_mem_wdata;
    logic [MAW-1:0]  r_mem_addr;
    logic [4:0]      r_wa;
    logic [CW-1:0]   r_cnt;
    logic            r_err, r_wen, r_ld, r_ldu, r_mem_we;
    logic [5:0]      w_op;
    logic [4:0]      w_rt, w_ra, w_rb, w_pa, w_pb, w_gwa;
    logic [9:0]      w_xo;
    logic [1:0]      w_ds;
    logic [XLEN-1:0] w_rd_a, w_rd_b, w_base, w_simm, w_uimm, w_dimm, w_ea, w_alu, w_gwd;
    logic            w_alu_ok, w_is_mem, w_upd, w_mem_ok, w_gwe;
    assign w_op = r_instr[31:26];
    assign w_rt = r_instr[25:21];
    assign w_ra = r_instr[20:16];
    assign w_rb = r_instr[15:11];
    assign w_xo = r_instr[10:1];
    assign w_ds = r_instr[1:0];
    // Port A carries RS for the logical forms, RA otherwise; port B is RB for X-form, RS otherwise.
    assign w_pa = (w_op == OP_ORI || w_op == OP_ANDI || (w_op == OP_X31 && w_xo == XO_AND)) ? w_rt : w_ra;
    assign w_pb = (w_op == OP_X31) ? w_rb : w_rt;
    assign w_base = (w_ra == 5'd0) ? '0 : w_rd_a;
    assign w_simm = {{(XLEN-16){r_instr[15]}}, r_instr[15:0]};
    assign w_uimm = {{(XLEN-16){1'b0}}, r_instr[15:0]};
    assign w_dimm = {{(XLEN-14){r_instr[15]}}, r_instr[15:2]};
    assign w_ea   = w_base + w_dimm;
    assign w_alu  = (w_op == OP_ADDI) ? w_base + w_simm :
                    (w_op == OP_ORI)  ? w_rd_a | w_uimm :
                    (w_op == OP_ANDI) ? w_rd_a & w_uimm :
                    (w_xo == XO_ADD)  ? w_rd_a + w_rd_b : w_rd_a & w_rd_b;
    assign w_alu_ok = w_op == OP_ADDI || w_op == OP_ORI || w_op == OP_ANDI ||
                      (w_op == OP_X31 && (w_xo == XO_ADD || w_xo == XO_AND));
    assign w_is_mem = w_op == OP_LD || w_op == OP_STD;
`ifdef UPOWER_LDST_UPDATE_EN
    assign w_upd = w_is_mem && w_ds == DS_UPDATE && w_ra != 5'd0 && (w_op == OP_STD || w_ra != w_rt);
`else
    assign w_upd = 1'b0;
`endif
    assign w_mem_ok = w_is_mem && (w_ds == DS_PLAIN || w_upd);
    // ldu writes the EA into RA on the ack cycle so WB's single write is free for RT.
    assign w_gwe = (r_state == ST_WB && r_wen) || (r_state == ST_MEM && mem_ack && r_ldu);
    assign w_gwa = (r_state == ST_MEM) ? w_ra : r_wa;
    assign w_gwd = (r_state == ST_MEM) ? r_ea : r_res;
    upower_gpr_file #(.XLEN(XLEN), .NREG(NREG)) u_gpr (
        .clk    (clk),
        .rst    (rst),
        .i_ra_a (w_pa),
        .i_ra_b (w_pb),
        .i_ra_d (dbg_raddr),
        .o_rd_a (w_rd_a),
        .o_rd_b (w_rd_b),
        .o_rd_d (dbg_rdata),
        .i_we   (w_gwe),
        .i_wa   (w_gwa),
        .i_wd   (w_gwd)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_instr     <= '0;
            r_res       <= '0;
            r_ea        <= '0;
            r_mem_wdata <= '0;
            r_mem_addr  <= '0;
            r_wa        <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_wen       <= 1'b0;
            r_ld        <= 1'b0;
            r_ldu       <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_err <= !(w_alu_ok || w_mem_ok);
                    r_wen <= w_alu_ok || (w_mem_ok && (w_op == OP_LD || w_upd));
                    r_wa  <= (w_alu_ok && (w_op == OP_ADDI || w_op == OP_X31 && w_xo == XO_ADD)) ? w_rt :
                             w_alu_ok ? w_ra : (w_op == OP_LD) ? w_rt : w_ra;
                    r_res <= w_alu_ok ? w_alu : w_ea;
                    r_ea  <= w_ea;
                    r_ld  <= w_op == OP_LD;
                    r_ldu <= w_upd && w_op == OP_LD;
                    r_cnt <= '0;
                    if (w_mem_ok) begin
                        r_mem_addr  <= w_ea[MAW-1:0];
                        r_mem_wdata <= w_rd_b;
                        r_mem_we    <= w_op == OP_STD;
                    end
                    r_state <= w_mem_ok ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (r_ld) r_res <= mem_rdata;
                        r_state <= ST_WB;
                    end else if (r_cnt == CW'(MEM_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_wen   <= 1'b0;
                        r_state <= ST_WB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign instr_ready = r_state == ST_IDLE;
    assign done        = r_state == ST_WB;
    assign err         = done && r_err;
    assign mem_req     = r_state == ST_MEM;
    assign mem_we      = mem_req && r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
endmodule
